// File: rtl/fpu_cmd_queue.sv
// Command queue in front of a single-issue FPU: buffers commands in a FIFO,
// issues one at a time, and returns each result with the tag it was accepted under.
`timescale 1ns/1ps
module fpu_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [5:0]                 cmd_op,
    input  logic [4:0]                 cmd_x1,
    input  logic [4:0]                 cmd_x2,
    input  logic [4:0]                 cmd_y,
    input  logic [31:0]                cmd_data,
    input  logic                       flush,
    output logic [5:0]                 fpu_operation,
    output logic [4:0]                 fpu_x1,
    output logic [4:0]                 fpu_x2,
    output logic [4:0]                 fpu_y,
    output logic [31:0]                fpu_in_data,
    output logic                       fpu_ready,
    input  logic                       fpu_valid,
    input  logic [31:0]                fpu_out_data,
    input  logic                       fpu_cond,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [31:0]                rsp_data,
    output logic                       rsp_cond,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic [$clog2(DEPTH):0]     count,
    output logic [1:0]                 fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; valid and payload stay stable until that edge.

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [5:0]       op_mem   [DEPTH];
    logic [4:0]       x1_mem   [DEPTH];
    logic [4:0]       x2_mem   [DEPTH];
    logic [4:0]       y_mem    [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem  [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [TAG_W-1:0] tag_cnt;
    logic [TAG_W-1:0] issue_tag;
    logic             push, pop;

    assign cmd_ready = (count < DEPTH_C) && !flush;
    assign push      = cmd_valid && cmd_ready;
    assign fpu_ready = (state == ISSUE);
    assign rsp_valid = (state == RESP);
    assign fsm_state = state;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0 && !flush) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (fpu_valid) state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    // Chain straight into the next issue so the FPU sees no idle gap.
                    if (count != '0 && !flush) begin
                        pop        = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Storage carries no reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr]   <= cmd_op;
            x1_mem[wr_ptr]   <= cmd_x1;
            x2_mem[wr_ptr]   <= cmd_x2;
            y_mem[wr_ptr]    <= cmd_y;
            data_mem[wr_ptr] <= cmd_data;
            tag_mem[wr_ptr]  <= tag_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            tag_cnt <= '0;
        end else begin
            if (push) tag_cnt <= tag_cnt + TAG_W'(1);
            if (flush) begin
                count  <= '0;
                rd_ptr <= wr_ptr;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Issue registers keep the last issued command visible while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpu_operation <= '0;
            fpu_x1        <= '0;
            fpu_x2        <= '0;
            fpu_y         <= '0;
            fpu_in_data   <= '0;
            issue_tag     <= '0;
        end else if (pop) begin
            fpu_operation <= op_mem[rd_ptr];
            fpu_x1        <= x1_mem[rd_ptr];
            fpu_x2        <= x2_mem[rd_ptr];
            fpu_y         <= y_mem[rd_ptr];
            fpu_in_data   <= data_mem[rd_ptr];
            issue_tag     <= tag_mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data <= '0;
            rsp_cond <= 1'b0;
            rsp_tag  <= '0;
        end else if (state == ISSUE && fpu_valid) begin
            rsp_data <= fpu_out_data;
            rsp_cond <= fpu_cond;
            rsp_tag  <= issue_tag;
        end
    end

endmodule

// File: tb/tb_fpu_cmd_queue.sv
// Directed bench for fpu_cmd_queue: an FPU model with programmable latency/stall
// and an in-order response scoreboard keyed on {cond, tag, data}.
`timescale 1ns/1ps
module tb_fpu_cmd_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int EW    = 1 + TAG_W + 32;
    localparam logic [5:0]  FPU_OPFMUL = 6'h02;
    localparam logic [31:0] ONE_F      = 32'h3f800000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_op = '0;
    logic [4:0]  cmd_x1 = '0, cmd_x2 = '0, cmd_y = '0;
    logic [31:0] cmd_data = '0;
    logic        flush = 1'b0;
    logic [5:0]  fpu_operation;
    logic [4:0]  fpu_x1, fpu_x2, fpu_y;
    logic [31:0] fpu_in_data;
    logic        fpu_ready;
    logic        fpu_valid = 1'b0;
    logic [31:0] fpu_out_data = '0;
    logic        fpu_cond = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_cond;
    logic [TAG_W-1:0] rsp_tag;
    logic [$clog2(DEPTH):0] count;
    logic [1:0]  fsm_state;

    logic [EW-1:0]    exp_q[$];
    logic [TAG_W-1:0] tb_tag = '0;
    int n_checks = 0;
    int n_fail   = 0;
    int fpu_lat  = 3;
    logic fpu_stall = 1'b0;

    fpu_cmd_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_x1(cmd_x1), .cmd_x2(cmd_x2), .cmd_y(cmd_y), .cmd_data(cmd_data),
        .flush(flush),
        .fpu_operation(fpu_operation), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2), .fpu_y(fpu_y),
        .fpu_in_data(fpu_in_data), .fpu_ready(fpu_ready),
        .fpu_valid(fpu_valid), .fpu_out_data(fpu_out_data), .fpu_cond(fpu_cond),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_cond(rsp_cond), .rsp_tag(rsp_tag),
        .count(count), .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    initial forever #5 clk = ~clk;

    // ---------------- FPU model ----------------
    // Answers fpu_lat cycles after fpu_ready rises: result = in_data ^ 1.0f, cond = x1[0].
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (fpu_ready && !fpu_stall && wait_cnt >= fpu_lat - 1) begin
                fpu_valid    = 1'b1;
                fpu_out_data = fpu_in_data ^ ONE_F;
                fpu_cond     = fpu_x1[0];
            end else begin
                fpu_valid = 1'b0;
            end
            if (fpu_ready) wait_cnt++;
            else           wait_cnt = 0;
        end
    end

    // ---------------- scoreboard ----------------
    initial begin
        logic [EW-1:0] exp_e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected: got tag=%0d data=%h, required no response", rsp_tag, rsp_data);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({rsp_cond, rsp_tag, rsp_data} !== exp_e) begin
                        n_fail++;
                        $display("FAIL rsp_order: got cond=%b tag=%0d data=%h, required cond=%b tag=%0d data=%h",
                                 rsp_cond, rsp_tag, rsp_data, exp_e[EW-1], exp_e[EW-2:32], exp_e[31:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1; cmd_valid = 1'b0; flush = 1'b0; fpu_stall = 1'b0; rsp_ready = 1'b1;
        exp_q.delete();
        tb_tag = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic push_cmd(input logic [5:0] op, input logic [4:0] x1, input logic [4:0] x2,
                            input logic [4:0] y, input logic [31:0] data);
        int waited;
        waited = 0;
        cmd_op = op; cmd_x1 = x1; cmd_x2 = x2; cmd_y = y; cmd_data = data;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL push_accept: cmd_ready=%b required 1 within 200 cycles", cmd_ready);
        end else begin
            exp_q.push_back({x1[0], tb_tag, data ^ ONE_F});
            tb_tag++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d responses outstanding, required 0", name, exp_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (fpu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_fpu_ready: got %b required 0", fpu_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
        n_checks++; if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d required 0", count); end
        n_checks++; if ({rsp_cond, rsp_tag, rsp_data} !== '0) begin n_fail++; $display("FAIL reset_rsp_fields: got %h required 0", {rsp_cond, rsp_tag, rsp_data}); end
        n_checks++; if ({fpu_operation, fpu_x1, fpu_x2, fpu_y, fpu_in_data} !== '0) begin
            n_fail++; $display("FAIL reset_fpu_fields: got %h required 0", {fpu_operation, fpu_x1, fpu_x2, fpu_y, fpu_in_data});
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready); end
    endtask

    task automatic test_single_op();
        apply_reset();
        fpu_lat = 3;
        push_cmd(FPU_OPFMUL, 5'd0, 5'd1, 5'd2, 32'h0);
        @(negedge clk);
        n_checks++; if (fpu_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_n: got %b required 0", fpu_ready); end
        n_checks++; if (count !== 1) begin n_fail++; $display("FAIL single_count_n: got %0d required 1", count); end
        @(negedge clk);
        n_checks++; if (fpu_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_n1: got %b required 1", fpu_ready); end
        n_checks++; if ({fpu_operation, fpu_x1, fpu_x2, fpu_y} !== {FPU_OPFMUL, 5'd0, 5'd1, 5'd2}) begin
            n_fail++; $display("FAIL single_fields: got op=%h x1=%0d x2=%0d y=%0d required op=%h x1=0 x2=1 y=2",
                               fpu_operation, fpu_x1, fpu_x2, fpu_y, FPU_OPFMUL);
        end
        n_checks++; if (count !== 0) begin n_fail++; $display("FAIL single_count_n1: got %0d required 0", count); end
        repeat (2) begin
            @(negedge clk);
            n_checks++; if (fpu_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_hold: got %b required 1", fpu_ready); end
        end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid: got %b required 1", rsp_valid); end
        n_checks++; if (fpu_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_drop: got %b required 0", fpu_ready); end
        n_checks++; if (rsp_data !== ONE_F) begin n_fail++; $display("FAIL single_rsp_data: got %h required %h", rsp_data, ONE_F); end
        n_checks++; if (rsp_tag !== 0) begin n_fail++; $display("FAIL single_rsp_tag: got %0d required 0", rsp_tag); end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_done: got %b required 0", rsp_valid); end
        n_checks++; if (fpu_y !== 5'd2) begin n_fail++; $display("FAIL single_idle_hold: fpu_y=%0d required 2", fpu_y); end
        wait_drain("single");
    endtask

    task automatic test_fill();
        apply_reset();
        fpu_lat = 3;
        fpu_stall = 1'b1;
        for (int i = 0; i < 5; i++) push_cmd(6'(i + 1), 5'(i), 5'(i + 2), 5'(i + 4), 32'(i) * 32'h100);
        @(negedge clk);
        n_checks++; if (count !== 4) begin n_fail++; $display("FAIL fill_count: got %0d required 4", count); end
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL fill_cmd_ready: got %b required 0", cmd_ready); end
        n_checks++; if (fpu_ready !== 1'b1) begin n_fail++; $display("FAIL fill_fpu_ready: got %b required 1", fpu_ready); end
        n_checks++; if (fpu_operation !== 6'd1) begin n_fail++; $display("FAIL fill_first_op: got %0d required 1", fpu_operation); end
        fpu_stall = 1'b0;
        wait_drain("fill");
    endtask

    task automatic test_back_pressure();
        int w;
        apply_reset();
        fpu_lat = 3;
        rsp_ready = 1'b0;
        push_cmd(6'h05, 5'd3, 5'd4, 5'd5, 32'h1111_0000);
        push_cmd(6'h06, 5'd6, 5'd7, 5'd8, 32'h2222_0000);
        w = 0;
        @(negedge clk);
        while (!rsp_valid && w < 50) begin w++; @(negedge clk); end
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rsp_arrive: got %b required 1", rsp_valid); end
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold[%0d]: got %b required 1", i, rsp_valid); end
            n_checks++; if (rsp_data !== 32'h2e91_0000) begin n_fail++; $display("FAIL bp_data_hold[%0d]: got %h required 2e910000", i, rsp_data); end
            n_checks++; if (fpu_ready !== 1'b0) begin n_fail++; $display("FAIL bp_no_issue[%0d]: fpu_ready=%b required 0", i, fpu_ready); end
            n_checks++; if (count !== 1) begin n_fail++; $display("FAIL bp_count[%0d]: got %0d required 1", i, count); end
            @(negedge clk);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (fpu_ready !== 1'b1) begin n_fail++; $display("FAIL bp_chain_issue: fpu_ready=%b required 1", fpu_ready); end
        n_checks++; if (count !== 0) begin n_fail++; $display("FAIL bp_chain_count: got %0d required 0", count); end
        n_checks++; if (fpu_in_data !== 32'h2222_0000) begin n_fail++; $display("FAIL bp_chain_data: got %h required 22220000", fpu_in_data); end
        wait_drain("bp");
    endtask

    task automatic test_flush();
        apply_reset();
        fpu_lat = 3;
        fpu_stall = 1'b1;
        for (int i = 0; i < 4; i++) push_cmd(6'(i + 8), 5'(i + 1), 5'(i), 5'(i), 32'hA000_0000 + 32'(i));
        @(negedge clk);
        n_checks++; if (count !== 3) begin n_fail++; $display("FAIL flush_pre_count: got %0d required 3", count); end
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL flush_cmd_ready: got %b required 0", cmd_ready); end
        @(posedge clk); #1 flush = 1'b0;
        repeat (3) void'(exp_q.pop_back());
        @(negedge clk);
        n_checks++; if (count !== 0) begin n_fail++; $display("FAIL flush_count: got %0d required 0", count); end
        n_checks++; if (fpu_ready !== 1'b1) begin n_fail++; $display("FAIL flush_inflight: fpu_ready=%b required 1", fpu_ready); end
        fpu_stall = 1'b0;
        wait_drain("flush");
        push_cmd(6'h0c, 5'd9, 5'd0, 5'd1, 32'h0000_0042);
        wait_drain("flush_next");
        n_checks++; if (rsp_tag !== 4'd4) begin n_fail++; $display("FAIL flush_next_tag: got %0d required 4", rsp_tag); end
    endtask

    task automatic test_wrap();
        apply_reset();
        fpu_lat = 1;
        for (int i = 0; i < (1 << TAG_W) + 3; i++)
            push_cmd(6'(i), 5'(i), 5'(31 - i), 5'(i + 7), 32'(i) * 32'h0101_0101);
        wait_drain("wrap");
        @(negedge clk);
        n_checks++; if (count !== 0) begin n_fail++; $display("FAIL wrap_count: got %0d required 0", count); end
        n_checks++; if (rsp_tag !== 4'd2) begin n_fail++; $display("FAIL wrap_last_tag: got %0d required 2", rsp_tag); end
    endtask

    task automatic test_reset_mid_issue();
        apply_reset();
        fpu_lat = 3;
        fpu_stall = 1'b1;
        push_cmd(6'h03, 5'd1, 5'd2, 5'd3, 32'h5555_5555);
        push_cmd(6'h04, 5'd2, 5'd3, 5'd4, 32'h6666_6666);
        @(negedge clk);
        n_checks++; if (fpu_ready !== 1'b1) begin n_fail++; $display("FAIL rmi_pre_ready: got %b required 1", fpu_ready); end
        @(posedge clk); #2 rst = 1'b1;
        #1;
        n_checks++; if (fpu_ready !== 1'b0) begin n_fail++; $display("FAIL rmi_ready_async: got %b required 0", fpu_ready); end
        n_checks++; if (count !== 0) begin n_fail++; $display("FAIL rmi_count: got %0d required 0", count); end
        exp_q.delete();
        tb_tag = '0;
        fpu_stall = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmi_no_rsp[%0d]: got %b required 0", i, rsp_valid); end
            n_checks++; if (fpu_ready !== 1'b0) begin n_fail++; $display("FAIL rmi_no_issue[%0d]: got %b required 0", i, fpu_ready); end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_single_op();
        test_fill();
        test_back_pressure();
        test_flush();
        test_wrap();
        test_reset_mid_issue();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded 200000 ns");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fpu_cmd_queue.md
FPU_CMD_QUEUE -- requirements
Module: fpu_cmd_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter TAG_W, default 4, meaning response tag width.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports cmd_valid input 1 / cmd_ready output 1  upstream command handshake.
REQ-006 SHALL have ports cmd_op input 6, cmd_x1 input 5, cmd_x2 input 5, cmd_y input 5, cmd_data input 32  command fields (FPU_OP* encodings from fpu_params.h).
REQ-007 SHALL have port flush  input  1  discard queued, not-yet-issued commands.
REQ-008 SHALL have ports fpu_operation output 6, fpu_x1 output 5, fpu_x2 output 5, fpu_y output 5, fpu_in_data output 32, fpu_ready output 1  request to fpu.
REQ-009 SHALL have ports fpu_valid input 1, fpu_out_data input 32, fpu_cond input 1  fpu completion.
REQ-010 SHALL have ports rsp_valid output 1 / rsp_ready input 1, rsp_data output 32, rsp_cond output 1, rsp_tag output TAG_W  downstream result handshake.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  queued (not issued) entries.

Function
REQ-012 SHALL accept a command on a rising edge where cmd_valid && cmd_ready, writing fields plus current tag counter into FIFO tail.
REQ-013 SHALL drive cmd_ready = (count < DEPTH) && !flush, independent of same-cycle pop.
REQ-014 SHALL increment the tag counter by 1 mod 2^TAG_W per accepted command; flush does not alter it.
REQ-015 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-016 IDLE: if count>0 and !flush, pop head into issue registers and enter ISSUE next edge; else stay.
REQ-017 ISSUE: fpu_ready=1 with fpu_* fields held stable from issue registers; on edge with fpu_valid=1 capture fpu_out_data, fpu_cond, entry tag into response registers, enter RESP.
REQ-018 SHALL drive fpu_ready=0 in IDLE and RESP, giving one-cycle deassert after fpu_valid.
REQ-019 SHALL ignore fpu_valid outside ISSUE.
REQ-020 RESP: rsp_valid=1, rsp_* stable; on edge with rsp_ready=1 go to ISSUE directly (popping head) if count>0 and !flush, else IDLE.
REQ-021 SHALL drive rsp_valid=0 outside RESP.
REQ-022 Minimum latency: command accepted at edge N into empty idle block -> fpu_ready high after edge N+1.
REQ-023 Simultaneous push and pop SHALL both take effect; count unchanged.
REQ-024 Flush SHALL set count to 0 and equalise pointers on that edge; in-flight ISSUE/RESP command completes normally; no pop that edge.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH; full/empty distinguished by count.
REQ-026 fpu_* fields in IDLE SHALL hold last issued values (no X).

Reset
REQ-027 On rst high, asynchronously: FSM=IDLE, count=0, pointers=0, tag counter=0, fpu_ready=0, rsp_valid=0, rsp_data=0, rsp_cond=0, rsp_tag=0, fpu_* fields=0.
REQ-028 Reset mid-ISSUE or mid-RESP SHALL abandon that command; no response emitted after release.
REQ-029 cmd_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-030 Single op: push FPU_OPFMUL x1=0,x2=1,y=2, fpu model returns 32'h3f800000 after 3 cycles -> fpu_ready high edge N+1 to fpu_valid edge, rsp_data=32'h3f800000, rsp_tag=0.
REQ-031 Fill: DEPTH=4, stall fpu_valid, push 5 cmds -> 1 issued, 4 queued, cmd_ready=0, count=4; release -> responses tags 0..4 in order.
REQ-032 Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid/rsp_data stable, fpu_ready stays 0, next cmd not issued until rsp_ready=1.
REQ-033 Flush: 3 queued + 1 in ISSUE, pulse flush -> count=0, in-flight response still delivered, next push gets tag 4.
REQ-034 Wrap: 2^TAG_W+3 back-to-back cmds -> tags wrap 15->0, FIFO pointers wrap, no loss/duplication.
REQ-035 Reset mid-ISSUE: assert rst while fpu_ready=1 -> fpu_ready=0 immediately, rsp_valid never asserts for that cmd, count=0.
